// File: rtl/fir_host_ctrl.sv
// rtl/fir_host_ctrl.sv - host-side coefficient/sample sequencer for the FIR filter core
//
// Purpose: buffers incoming samples in a small FIFO, holds a local coefficient
// file, and walks the fir_load_coeff / fir_data_ready strobes against the
// filter's fir_modwait acknowledge. Each filtered result is captured, with its
// error flag, into a valid/ready result port.
// Optional feature macro: FIR_HOST_TIMEOUT_EN (fir_modwait watchdog).
//
// Ports:
//   clk, n_reset                      clock, asynchronous active-low reset
//   coeff_wr, coeff_addr, coeff_wdata local coefficient file write
//   coeff_go                          request a full coefficient reload
//   smp_valid, smp_data, smp_ready    sample input, push on valid && ready
//   res_valid, res_data, res_err      captured result
//   res_ready                         result consumed on valid && ready
//   fir_sample_data, fir_coefficient  data towards the filter
//   fir_data_ready, fir_load_coeff    strobes towards the filter
//   fir_modwait, fir_out, fir_err     acknowledge and result from the filter
//   busy                              sequencer not idle
//   timeout                           sticky watchdog flag
module fir_host_ctrl #(
   parameter int FIFO_DEPTH     = 4,
   parameter int NUM_COEFF      = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        coeff_wr,
   input  logic [2:0]  coeff_addr,
   input  logic [15:0] coeff_wdata,
   input  logic        coeff_go,
   input  logic        smp_valid,
   input  logic [15:0] smp_data,
   output logic        smp_ready,
   output logic        res_valid,
   output logic [15:0] res_data,
   output logic        res_err,
   input  logic        res_ready,
   output logic [15:0] fir_sample_data,
   output logic [15:0] fir_coefficient,
   output logic        fir_data_ready,
   output logic        fir_load_coeff,
   input  logic        fir_modwait,
   input  logic [15:0] fir_out,
   input  logic        fir_err,
   output logic        busy,
   output logic        timeout
);

   localparam int          PW          = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] LP_DEPTH    = (PW+1)'(FIFO_DEPTH);
   localparam logic [3:0]  LP_NCOEFF   = 4'(NUM_COEFF);
   localparam logic [2:0]  LP_LAST_IDX = 3'(NUM_COEFF - 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       NUM_COEFF < 1 || NUM_COEFF > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("fir_host_ctrl: illegal parameter value");
   end

   typedef enum logic [2:0] {IDLE, C_REQ, C_ACK, S_REQ, S_ACK} state_t;

   state_t        r_state, w_next;
   logic [2:0]    r_idx, w_next_idx;
   logic          r_pending;
   logic          r_init;

   logic [15:0]   r_fifo_mem [0:FIFO_DEPTH-1];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_count;

   // Sized to the full address space so coeff_addr indexes it directly;
   // entries at or above NUM_COEFF are never written and stay 0.
   logic [15:0]   r_coeff [0:7];

   logic          r_res_valid, r_res_err;
   logic [15:0]   r_res_data;
   logic [15:0]   r_smp_out, r_coeff_out;
   logic          r_load_coeff, r_data_ready, r_busy;

   logic          w_push, w_pop, w_capture, w_cap_err, w_coeff_wen, w_fifo_nonempty;
   logic [15:0]   w_cap_data;

`ifdef FIR_HOST_TIMEOUT_EN
   localparam int          TW         = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] LP_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] r_tcnt;
   logic          r_timeout;
   logic          w_to_fire;
`endif

   // r_init keeps smp_ready low while in reset and for nothing longer.
   assign smp_ready       = r_init && (r_count != LP_DEPTH);
   assign w_push          = smp_valid && smp_ready;
   assign w_fifo_nonempty = (r_count != '0);
   assign w_coeff_wen     = coeff_wr && ({1'b0, coeff_addr} < LP_NCOEFF) &&
                            (r_state != C_REQ) && (r_state != C_ACK);

   always_comb begin
      w_next     = r_state;
      w_next_idx = r_idx;
      w_pop      = 1'b0;
      w_capture  = 1'b0;
      w_cap_data = fir_out;
      w_cap_err  = fir_err;
`ifdef FIR_HOST_TIMEOUT_EN
      w_to_fire  = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (r_pending) begin
               w_next     = C_REQ;
               w_next_idx = 3'd0;
            end else if (w_fifo_nonempty && (!r_res_valid || res_ready)) begin
               w_pop  = 1'b1;
               w_next = S_REQ;
            end
         end
         C_REQ: if (fir_modwait) w_next = C_ACK;
         C_ACK: begin
            if (!fir_modwait) begin
               if (r_idx == LP_LAST_IDX) begin
                  w_next = IDLE;
               end else begin
                  w_next_idx = r_idx + 3'd1;
                  w_next     = C_REQ;
               end
            end
         end
         S_REQ: if (fir_modwait) w_next = S_ACK;
         S_ACK: begin
            if (!fir_modwait) begin
               w_capture = 1'b1;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
`ifdef FIR_HOST_TIMEOUT_EN
      // Watchdog only fires when the awaited edge has not arrived this cycle.
      if (r_state != IDLE && w_next == r_state && r_tcnt == LP_TO_LAST) begin
         w_next    = IDLE;
         w_to_fire = 1'b1;
         if (r_state == S_REQ || r_state == S_ACK) begin
            w_capture  = 1'b1;
            w_cap_data = 16'd0;
            w_cap_err  = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state      <= IDLE;
         r_idx        <= 3'd0;
         r_pending    <= 1'b0;
         r_init       <= 1'b0;
         r_load_coeff <= 1'b0;
         r_data_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_smp_out    <= 16'd0;
         r_coeff_out  <= 16'd0;
      end else begin
         r_state      <= w_next;
         r_idx        <= w_next_idx;
         r_init       <= 1'b1;
         // Strobes and busy are registered copies of the next state.
         r_load_coeff <= (w_next == C_REQ);
         r_data_ready <= (w_next == S_REQ);
         r_busy       <= (w_next != IDLE);
         if (r_state == IDLE && w_next == C_REQ) r_pending <= 1'b0;
         else if (coeff_go)                      r_pending <= 1'b1;
         if (w_next == C_REQ) r_coeff_out <= r_coeff[w_next_idx];
         if (w_pop)           r_smp_out   <= r_fifo_mem[r_rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo_mem[r_wr_ptr] <= smp_data;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < 8; i++) r_coeff[i] <= 16'd0;
      end else if (w_coeff_wen) begin
         r_coeff[coeff_addr] <= coeff_wdata;
      end
   end

   // A capture in the same cycle as res_ready replaces the consumed result.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_res_valid <= 1'b0;
         r_res_data  <= 16'd0;
         r_res_err   <= 1'b0;
      end else if (w_capture) begin
         r_res_valid <= 1'b1;
         r_res_data  <= w_cap_data;
         r_res_err   <= w_cap_err;
      end else if (res_ready) begin
         r_res_valid <= 1'b0;
      end
   end

`ifdef FIR_HOST_TIMEOUT_EN
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_tcnt    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_next != r_state)  r_tcnt <= '0;
         else if (r_state != IDLE) r_tcnt <= r_tcnt + 1'b1;
         if (w_to_fire)     r_timeout <= 1'b1;
         else if (coeff_go) r_timeout <= 1'b0;
      end
   end
   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

   assign res_valid       = r_res_valid;
   assign res_data        = r_res_data;
   assign res_err         = r_res_err;
   assign fir_sample_data = r_smp_out;
   assign fir_coefficient = r_coeff_out;
   assign fir_data_ready  = r_data_ready;
   assign fir_load_coeff  = r_load_coeff;
   assign busy            = r_busy;

endmodule

// File: tb/tb_fir_host_ctrl.sv
// tb/tb_fir_host_ctrl.sv - self-checking bench for fir_host_ctrl
`timescale 1ns/1ps
module tb_fir_host_ctrl;
   localparam int TIMEOUT_CYCLES = 64;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        coeff_wr = 1'b0;
   logic [2:0]  coeff_addr = 3'd0;
   logic [15:0] coeff_wdata = 16'd0;
   logic        coeff_go = 1'b0;
   logic        smp_valid = 1'b0;
   logic [15:0] smp_data = 16'd0;
   logic        smp_ready;
   logic        res_valid;
   logic [15:0] res_data;
   logic        res_err;
   logic        res_ready = 1'b0;
   logic [15:0] fir_sample_data, fir_coefficient;
   logic        fir_data_ready, fir_load_coeff;
   logic        fir_modwait = 1'b0;
   logic [15:0] fir_out = 16'd0;
   logic        fir_err = 1'b0;
   logic        busy, timeout;

   always #5 clk = ~clk;

   fir_host_ctrl dut (
      .clk(clk), .n_reset(n_reset),
      .coeff_wr(coeff_wr), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
      .coeff_go(coeff_go),
      .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
      .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .res_ready(res_ready),
      .fir_sample_data(fir_sample_data), .fir_coefficient(fir_coefficient),
      .fir_data_ready(fir_data_ready), .fir_load_coeff(fir_load_coeff),
      .fir_modwait(fir_modwait), .fir_out(fir_out), .fir_err(fir_err),
      .busy(busy), .timeout(timeout)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Filter model: acks a strobe m_delay cycles after it appears, stays busy
   // m_busy cycles, returns sample+1 and flags fir_err on sample #m_err_idx.
   int          m_delay = 3, m_busy = 2;
   bit          m_mute = 1'b0, m_active = 1'b0;
   int          m_hold_err = 0, m_proto_err = 0;
   int          m_smp_cnt = 0, m_err_idx = -1;
   logic [15:0] m_coeffs[$];

   always begin : filter_model
      logic        is_c;
      logic [15:0] v;
      @(negedge clk);
      if (!m_mute && n_reset && (fir_load_coeff || fir_data_ready)) begin
         m_active = 1'b1;
         is_c = fir_load_coeff;
         v = is_c ? fir_coefficient : fir_sample_data;
         if (is_c) m_coeffs.push_back(v);
         else begin
            fir_out = v + 16'd1;
            fir_err = (m_smp_cnt == m_err_idx);
            m_smp_cnt++;
         end
         for (int k = 1; k < m_delay; k++) begin
            @(negedge clk);
            if ((is_c ? fir_load_coeff : fir_data_ready) !== 1'b1 ||
                (is_c ? fir_coefficient : fir_sample_data) !== v) m_hold_err++;
         end
         fir_modwait = 1'b1;
         @(negedge clk);
         if ((is_c ? fir_load_coeff : fir_data_ready) !== 1'b0) m_proto_err++;
         for (int k = 1; k < m_busy; k++) @(negedge clk);
         fir_modwait = 1'b0;
         m_active = 1'b0;
      end
   end

   logic [16:0] got_q[$];
   logic [16:0] exp_q[$];
   int          n_pushed = 0;

   always @(negedge clk) begin
      if (n_reset && res_valid && res_ready) got_q.push_back({res_err, res_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coeff_write(input logic [2:0] a, input logic [15:0] d);
      coeff_wr = 1'b1; coeff_addr = a; coeff_wdata = d;
      tick();
      coeff_wr = 1'b0;
   endtask

   task automatic pulse_go();
      coeff_go = 1'b1;
      tick();
      coeff_go = 1'b0;
   endtask

   task automatic wait_busy(input logic lvl, input string tag);
      int n = 0;
      while (busy !== lvl && n < 2000) begin tick(); n++; end
      check(tag, busy, lvl);
   endtask

   task automatic push(input logic [15:0] d, input string tag);
      int n = 0;
      smp_valid = 1'b1; smp_data = d;
      while (!smp_ready && n < 2000) begin tick(); n++; end
      check(tag, smp_ready, 1);
      exp_q.push_back({(n_pushed == m_err_idx), d + 16'd1});
      n_pushed++;
      tick();
      smp_valid = 1'b0;
   endtask

   task automatic drain_and_compare(input string tag);
      int n = 0;
      res_ready = 1'b1;
      while (got_q.size() < exp_q.size() && n < 5000) begin tick(); n++; end
      repeat (3) tick();
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_res%0d", tag, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [15:0] cv[4];
      int n;

      // Reset state
      repeat (3) tick();
      check("rst_smp_ready", smp_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_strobes", {fir_load_coeff, fir_data_ready}, 0);
      check("rst_timeout", timeout, 0);
      n_reset = 1'b1;
      tick();
      check("post_rst_smp_ready", smp_ready, 1);

      // Directed coefficient reload 1,2,3,4
      for (int i = 0; i < 4; i++) coeff_write(3'(i), 16'(i + 1));
      pulse_go();
      wait_busy(1'b1, "c1_busy_rise");
      wait_busy(1'b0, "c1_busy_fall");
      check("c1_count", m_coeffs.size(), 4);
      for (int i = 0; i < 4 && i < m_coeffs.size(); i++)
         check($sformatf("c1_coeff%0d", i), m_coeffs[i], i + 1);

      // Random coefficients, out-of-range write, write during reload, collapsed requests
      m_coeffs.delete();
      for (int i = 0; i < 4; i++) begin
         cv[i] = 16'($urandom);
         coeff_write(3'(i), cv[i]);
      end
      coeff_write(3'd4, 16'hDEAD);
      coeff_write(3'd7, 16'hDEAD);
      pulse_go();
      wait_busy(1'b1, "c2_busy_rise");
      coeff_write(3'd3, 16'hBEEF);
      pulse_go();
      pulse_go();
      n = 0;
      while (m_coeffs.size() < 8 && n < 2000) begin tick(); n++; end
      wait_busy(1'b0, "c2_busy_fall");
      repeat (30) tick();
      check("c2_collapsed_count", m_coeffs.size(), 8);
      for (int i = 0; i < 8 && i < m_coeffs.size(); i++)
         check($sformatf("c2_coeff%0d", i), m_coeffs[i], cv[i % 4]);

      // Two directed samples
      res_ready = 1'b1;
      push(16'h0010, "s1_push0");
      push(16'h0020, "s1_push1");
      drain_and_compare("s1");

      // Error on the second of two samples
      m_err_idx = n_pushed + 1;
      push(16'($urandom), "e_push0");
      push(16'($urandom), "e_push1");
      drain_and_compare("err");

      // Result held, FIFO fills at 4, next sample issues only after res_ready
      res_ready = 1'b0;
      push(16'h0A00, "h_pushA");
      n = 0;
      while (!res_valid && n < 500) begin tick(); n++; end
      check("h_res_held", res_valid, 1);
      for (int i = 1; i <= 4; i++) push(16'(16'h0A00 + i), $sformatf("h_push%0d", i));
      check("h_full_not_ready", smp_ready, 0);
      n = m_smp_cnt;
      smp_valid = 1'b1; smp_data = 16'h0A05;
      repeat (10) tick();
      check("h_still_full", smp_ready, 0);
      check("h_not_issued", fir_data_ready, 0);
      check("h_model_idle", m_smp_cnt, n);
      res_ready = 1'b1;
      tick();
      check("h_issue_after_ready", fir_data_ready, 1);
      push(16'h0A05, "h_push5");
      push(16'h0A06, "h_push6");
      drain_and_compare("hold");

      // Randomised traffic with random filter timing and random back-pressure
      check("r_align", n_pushed, m_smp_cnt);
      m_err_idx = n_pushed + 5;
      for (int r = 0; r < 3; r++) begin
         m_delay = $urandom_range(1, 5);
         m_busy  = $urandom_range(1, 4);
         for (int c = 0; c < 80; c++) begin
            smp_valid = 1'($urandom_range(0, 1));
            smp_data  = 16'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            if (smp_valid && smp_ready) begin
               exp_q.push_back({(n_pushed == m_err_idx), smp_data + 16'd1});
               n_pushed++;
            end
            tick();
         end
         smp_valid = 1'b0;
         drain_and_compare($sformatf("rnd%0d", r));
      end
      check("strobe_held_until_ack", m_hold_err, 0);
      check("strobe_drops_after_ack", m_proto_err, 0);
      m_delay = 3; m_busy = 2;

      // modwait already high when the request starts: no hang
      m_mute = 1'b1;
      fir_modwait = 1'b1;
      push(16'h0777, "mw_push");
      wait_busy(1'b1, "mw_busy_rise");
      repeat (3) tick();
      fir_modwait = 1'b0;
      wait_busy(1'b0, "mw_no_hang");
      check("mw_strobe_low", fir_data_ready, 0);
      repeat (3) tick();
      got_q.delete();
      exp_q.delete();

`ifdef FIR_HOST_TIMEOUT_EN
      // Filter never acknowledges
      res_ready = 1'b0;
      push(16'h0055, "to_push");
      n = 0;
      while (!fir_data_ready && n < 100) begin tick(); n++; end
      check("to_strobe_seen", fir_data_ready, 1);
      n = 0;
      while (fir_data_ready && n < 1000) begin tick(); n++; end
      check("to_strobe_cycles", n, TIMEOUT_CYCLES);
      check("to_flag", timeout, 1);
      check("to_res_valid", res_valid, 1);
      check("to_res_err", res_err, 1);
      check("to_res_data", res_data, 0);
      check("to_busy", busy, 0);
      m_mute = 1'b0;
      pulse_go();
      check("to_cleared", timeout, 0);
      wait_busy(1'b1, "to_reload_rise");
      wait_busy(1'b0, "to_reload_fall");
      res_ready = 1'b1;
      repeat (3) tick();
      got_q.delete();
      exp_q.delete();
`else
      check("timeout_tied_low", timeout, 0);
`endif
      m_mute = 1'b0;

      // Asynchronous reset in the middle of a sample transfer
      m_delay = 6;
      res_ready = 1'b1;
      push(16'h0123, "ar_push0");
      push(16'h0456, "ar_push1");
      n = 0;
      while (!fir_data_ready && n < 100) begin tick(); n++; end
      check("ar_strobe_before", fir_data_ready, 1);
      n_reset = 1'b0;
      #1;
      check("ar_strobe_dropped", fir_data_ready, 0);
      check("ar_busy", busy, 0);
      check("ar_smp_ready", smp_ready, 0);
      n = 0;
      while (m_active && n < 100) begin tick(); n++; end
      check("ar_model_idle", m_active, 0);
      tick();
      n_reset = 1'b1;
      m_delay = 3;
      got_q.delete();
      exp_q.delete();
      repeat (20) tick();
      check("ar_fifo_lost", got_q.size(), 0);
      check("ar_idle", busy, 0);
      m_coeffs.delete();
      pulse_go();
      wait_busy(1'b1, "ar_reload_rise");
      wait_busy(1'b0, "ar_reload_fall");
      check("ar_reload_count", m_coeffs.size(), 4);
      for (int i = 0; i < 4 && i < m_coeffs.size(); i++)
         check($sformatf("ar_coeff%0d_zero", i), m_coeffs[i], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fir_host_ctrl.md
Name: fir_host_ctrl

Overview:
- Initiator-side driver for the FIR filter core: the host end of the filter's coefficient-load and sample handshake.
- Buffers incoming samples in a small FIFO and holds a local coefficient register file.
- Sequences `load_coeff` and `data_ready` strobes against the filter's `modwait` acknowledge.
- Captures each filtered result plus the error flag into a valid/ready result port.
- Sits between the system sample source and the FIR filter top level, on the same clock.

Parameters:
- FIFO_DEPTH, 4, sample FIFO entries; power of two, minimum 2.
- NUM_COEFF, 4, number of coefficients sent per reload; 1..8.
- TIMEOUT_CYCLES, 64, maximum cycles spent waiting on one `modwait` edge. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- coeff_wr  in  1  write strobe for the local coefficient file.
- coeff_addr  in  3  coefficient index, 0..NUM_COEFF-1.
- coeff_wdata  in  16  coefficient value.
- coeff_go  in  1  one-cycle request to send all coefficients to the filter.
- smp_valid  in  1  input sample valid.
- smp_data  in  16  input sample.
- smp_ready  out  1  FIFO not full; a push occurs when smp_valid && smp_ready.
- res_valid  out  1  result held.
- res_data  out  16  captured filter output.
- res_err  out  1  captured filter error, or timeout error.
- res_ready  in  1  result consumed when res_valid && res_ready.
- fir_sample_data  out  16  to filter sample input.
- fir_coefficient  out  16  to filter coefficient input.
- fir_data_ready  out  1  sample strobe to filter.
- fir_load_coeff  out  1  coefficient strobe to filter.
- fir_modwait  in  1  filter busy/acknowledge, synchronous to clk.
- fir_out  in  16  filter result.
- fir_err  in  1  filter error.
- busy  out  1  FSM not in IDLE.
- timeout  out  1  sticky watchdog flag; constant 0 without the optional feature.

Behaviour:
- Reset: all outputs 0 (smp_ready is 0 during reset and 1 from the first cycle after release); FIFO empty; coefficient file 0; FSM IDLE; reload-pending flag 0.
- All outputs are registered except smp_ready, which is decoded from the FIFO count.
- FIFO:
  - Push on smp_valid && smp_ready.
  - Pop only on the IDLE->S_REQ transition.
  - A simultaneous push and pop while full is not possible: smp_ready is low when full.
  - Occupancy wraps by pointer arithmetic modulo FIFO_DEPTH.
- Coefficient file:
  - coeff_wr writes coeff[coeff_addr] at the clock edge.
  - Writes with addr >= NUM_COEFF are ignored.
  - Writes are ignored while the FSM is in C_REQ or C_ACK.
- coeff_go sets the pending flag; it is cleared when C_REQ is entered. Multiple requests before service collapse to one reload.
- FSM states: IDLE, C_REQ, C_ACK, S_REQ, S_ACK.
  - IDLE, priority 1: if pending, go to C_REQ with idx=0.
  - IDLE, priority 2: else if FIFO not empty and (!res_valid or res_ready), pop and go to S_REQ.
  - C_REQ: fir_load_coeff=1, fir_coefficient=coeff[idx]. When fir_modwait==1, go to C_ACK; fir_load_coeff drops the next cycle.
  - C_ACK: fir_load_coeff=0. When fir_modwait==0: if idx==NUM_COEFF-1, go to IDLE; else idx++ and go to C_REQ.
  - S_REQ: fir_data_ready=1, fir_sample_data=popped sample, held stable. When fir_modwait==1, go to S_ACK.
  - S_ACK: fir_data_ready=0. When fir_modwait==0, capture res_data=fir_out and res_err=fir_err, set res_valid, go to IDLE.
- fir_sample_data and fir_coefficient keep their last value outside the request states.
- Minimum sample round trip, assuming modwait rises 3 cycles after the strobe and falls N cycles later, is 1 (pop) + 3 + N + 1 cycles.
- res_valid:
  - Clears on res_ready.
  - If a capture and res_ready occur in the same cycle, the new result wins and res_valid stays 1.
- fir_modwait already high on entry to C_REQ or S_REQ is treated as the acknowledge. The strobe lasts 1 cycle; the filter synchroniser may miss it. The bench checks this case for no FSM hang only.
- Asynchronous reset mid-transfer:
  - Strobes drop immediately.
  - FIFO contents are lost.
  - Any in-progress coefficient reload is abandoned; the coefficient file returns to 0.

Optional Feature:
- Macro: FIR_HOST_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on every state change and increments in C_REQ, C_ACK, S_REQ and S_ACK.
  - When the counter reaches TIMEOUT_CYCLES-1 without the awaited modwait edge, the FSM goes to IDLE, strobes drop and timeout is set (sticky).
  - In S_REQ/S_ACK, a result with res_data=0 and res_err=1 is also produced.
  - In C_REQ/C_ACK, the reload is abandoned.
  - timeout is cleared by coeff_go.
- Undefined: no counter; the FSM waits indefinitely; timeout is tied to 0.

Test Plan:
- Reset, then write coeff[0..3]=0x0001,0x0002,0x0003,0x0004 and pulse coeff_go; model acks each strobe after 3 cycles, busy 2 cycles -> four fir_load_coeff pulses carrying 1,2,3,4 in order, then IDLE, busy=0.
- Push samples 0x0010,0x0020; model returns fir_out=sample+1 -> res_data 0x0011 then 0x0021, res_err=0, each strobe held until modwait=1.
- Push 6 samples back-to-back with FIFO_DEPTH=4 and a slow model -> smp_ready low after 4 accepted pushes, no loss, output order preserved.
- Hold res_ready=0 with 2 samples queued -> first result held, second sample not issued until res_ready=1, then it issues on the following IDLE.
- Model returns fir_err=1 on the second sample -> res_err=1 on that result only.
- With FIR_HOST_TIMEOUT_EN and a model that never raises modwait -> after 64 cycles in S_REQ: strobe drops, timeout=1, res_valid=1, res_err=1, res_data=0; a later coeff_go clears timeout.
